// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 16-bit processor.
//
// Sequence: fetch an instruction word over a request/ready handshake, strobe
// the decoder, test the condition field against the ALU flags, then run the
// ALU, a data-memory access, register write-back, a jump or a halt.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   imem_req/addr/ready/data   instruction fetch handshake (addr = pc)
//   ir                    instruction register, drives the decoder
//   decode                decoder strobe (DECODE state)
//   op_code, cond         decoder fields (ir[13:10], ir[15:14])
//   flag_z, flag_n        registered ALU flags, sampled in DECODE only
//   branch_target         jump address from the register file
//   alu_en                ALU execute strobe
//   dmem_req/we/ready     data memory handshake
//   reg_we                register file write enable
//   halted                high in HALT
//   state                 current state encoding
//   retire_count          completed instructions, wraps at 16 bits
module cpu_sequencer #(
  parameter int unsigned          PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [15:0]         imem_data,
  output logic [15:0]         ir,
  output logic                decode,
  input  logic [3:0]          op_code,
  input  logic [1:0]          cond,
  input  logic                flag_z,
  input  logic                flag_n,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                alu_en,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                reg_we,
  output logic                halted,
  output logic [2:0]          state,
  output logic [15:0]         retire_count
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1101;
  localparam logic [3:0] OP_JUMP  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  logic [2:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [15:0]         r_retire;
  logic                r_is_store;

  logic [2:0]          w_state_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [15:0]         w_ir_nxt;
  logic                w_retire_inc;
  logic                w_is_store_nxt;
  logic                w_cond_pass;

  always_comb begin
    w_cond_pass = 1'b0;
    case (cond)
      2'b00:   w_cond_pass = 1'b1;
      2'b01:   w_cond_pass = flag_z;
      2'b10:   w_cond_pass = ~flag_z;
      default: w_cond_pass = flag_n;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_retire_inc   = 1'b0;
    w_is_store_nxt = r_is_store;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          w_ir_nxt    = imem_data;
          w_pc_nxt    = r_pc + PC_WIDTH'(1);
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_cond_pass) begin
          w_retire_inc = 1'b1;
          w_state_nxt  = S_FETCH;
        end else begin
          // Load/store class is captured here so MEM never re-reads op_code.
          case (op_code)
            OP_LOAD: begin
              w_is_store_nxt = 1'b0;
              w_state_nxt    = S_MEM;
            end
            OP_STORE: begin
              w_is_store_nxt = 1'b1;
              w_state_nxt    = S_MEM;
            end
            OP_JUMP: begin
              w_pc_nxt     = branch_target;
              w_retire_inc = 1'b1;
              w_state_nxt  = S_FETCH;
            end
            OP_HALT: begin
              w_retire_inc = 1'b1;
              w_state_nxt  = S_HALT;
            end
            default: begin
              w_is_store_nxt = 1'b0;
              w_state_nxt    = S_EXECUTE;
            end
          endcase
        end
      end
      S_EXECUTE:   w_state_nxt = S_WRITEBACK;
      S_MEM: begin
        if (dmem_ready) begin
          if (r_is_store) begin
            w_retire_inc = 1'b1;
            w_state_nxt  = S_FETCH;
          end else begin
            w_state_nxt  = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        w_retire_inc = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_HALT:      w_state_nxt = S_HALT;
      default:     w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_retire   <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_is_store <= w_is_store_nxt;
      if (w_retire_inc) r_retire <= r_retire + 16'd1;
    end
  end

  // Moore strobes, gated by reset so FETCH (the reset state) does not
  // request while reset is still held.
  assign imem_req     = ~reset & (r_state == S_FETCH);
  assign decode       = ~reset & (r_state == S_DECODE);
  assign alu_en       = ~reset & (r_state == S_EXECUTE);
  assign dmem_req     = ~reset & (r_state == S_MEM);
  assign dmem_we      = ~reset & (r_state == S_MEM) & r_is_store;
  assign reg_we       = ~reset & (r_state == S_WRITEBACK);
  assign halted       = ~reset & (r_state == S_HALT);

  assign imem_addr    = r_pc;
  assign ir           = r_ir;
  assign state        = r_state;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic        decode;
  logic [3:0]  op_code;
  logic [1:0]  cond;
  logic        flag_z;
  logic        flag_n;
  logic [7:0]  branch_target;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        reg_we;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retire_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Decoder fields come straight from the instruction register.
  assign op_code = ir[13:10];
  assign cond    = ir[15:14];

  cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .ir(ir), .decode(decode),
    .op_code(op_code), .cond(cond), .flag_z(flag_z), .flag_n(flag_n),
    .branch_target(branch_target), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_we(reg_we), .halted(halted), .state(state),
    .retire_count(retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_data = 16'h0000;
    flag_z = 1'b0; flag_n = 1'b0; branch_target = 8'h00; dmem_ready = 1'b0;
    tick(); tick();
    chk("rst_state",  state, 0);
    chk("rst_pc",     imem_addr, 0);
    chk("rst_ir",     ir, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", {imem_req, decode, alu_en, dmem_req, dmem_we, reg_we}, 0);

    // ALU 0x0000, imem_ready tied high
    imem_ready = 1'b1;
    reset = 1'b0; #1;
    chk("alu_c1_state", state, 0);
    chk("alu_c1_req",   imem_req, 1);
    tick();
    chk("alu_c2_state",  state, 1);
    chk("alu_c2_decode", decode, 1);
    chk("alu_c2_pc",     imem_addr, 1);
    chk("alu_c2_req",    imem_req, 0);
    tick();
    chk("alu_c3_state", state, 2);
    chk("alu_c3_alu",   {alu_en, reg_we}, 2'b10);
    tick();
    chk("alu_c4_state", state, 4);
    chk("alu_c4_we",    {alu_en, reg_we}, 2'b01);
    tick();
    chk("alu_done_state",  state, 0);
    chk("alu_done_retire", retire_count, 1);
    chk("alu_done_pc",     imem_addr, 1);

    // cond 01 with Z=0 fails
    imem_data = 16'h4000; flag_z = 1'b0;
    tick();
    chk("cz0_state", state, 1);
    chk("cz0_ir",    ir, 16'h4000);
    chk("cz0_strb",  {alu_en, reg_we}, 0);
    tick();
    chk("cz0_state2", state, 0);
    chk("cz0_strb2",  {alu_en, reg_we}, 0);
    chk("cz0_retire", retire_count, 2);
    chk("cz0_pc",     imem_addr, 2);

    // cond 01 with Z=1 executes; flags change after DECODE must not matter
    flag_z = 1'b1;
    tick();
    chk("cz1_state", state, 1);
    tick();
    flag_z = 1'b0;
    chk("cz1_exec", state, 2);
    tick();
    chk("cz1_wb", state, 4);
    tick();
    chk("cz1_retire", retire_count, 3);
    chk("cz1_pc",     imem_addr, 3);

    // fetch wait state holds outputs
    imem_ready = 1'b0;
    tick();
    chk("fwait_state", state, 0);
    chk("fwait_req",   imem_req, 1);
    chk("fwait_pc",    imem_addr, 3);
    chk("fwait_ir",    ir, 16'h4000);

    // LOAD with dmem_ready low for 3 cycles
    imem_ready = 1'b1; imem_data = 16'h3000;
    tick();
    chk("ld_dec", state, 1);
    tick();
    chk("ld_m1", {state, dmem_req, dmem_we}, {3'd3, 2'b10});
    tick();
    chk("ld_m2", {state, dmem_req, dmem_we}, {3'd3, 2'b10});
    tick();
    chk("ld_m3", {state, dmem_req, dmem_we}, {3'd3, 2'b10});
    tick();
    dmem_ready = 1'b1;
    chk("ld_m4", {state, dmem_req, dmem_we}, {3'd3, 2'b10});
    tick();
    chk("ld_wb", {state, reg_we, dmem_req}, {3'd4, 2'b10});
    tick();
    chk("ld_retire", retire_count, 4);
    chk("ld_pc",     imem_addr, 4);

    // STORE, zero wait (dmem_ready still high)
    imem_data = 16'h3400;
    tick();
    chk("st_dec", state, 1);
    tick();
    chk("st_mem", {state, dmem_req, dmem_we, reg_we}, {3'd3, 3'b110});
    tick();
    chk("st_done", {state, reg_we}, {3'd0, 1'b0});
    chk("st_retire", retire_count, 5);
    dmem_ready = 1'b0;

    // JUMP to 0x5A
    imem_data = 16'h3800; branch_target = 8'h5A;
    tick();
    chk("jmp_dec_pc", imem_addr, 6);
    tick();
    chk("jmp_state",  state, 0);
    chk("jmp_addr",   imem_addr, 8'h5A);
    chk("jmp_retire", retire_count, 6);

    // jump to 0xFF, then ALU op wraps pc to 0
    branch_target = 8'hFF;
    tick(); tick();
    chk("jff_addr", imem_addr, 8'hFF);
    imem_data = 16'h0000;
    tick();
    chk("wrap_pc", imem_addr, 8'h00);
    tick(); tick(); tick();
    chk("wrap_retire", retire_count, 8);
    chk("wrap_state",  state, 0);

    // cond 11 with N=0 fails, cond 10 with Z=1 fails
    imem_data = 16'hC000; flag_n = 1'b0;
    tick(); tick();
    chk("cn_state",  state, 0);
    chk("cn_retire", retire_count, 9);
    imem_data = 16'h8000; flag_z = 1'b1;
    tick();
    chk("cnz_dec", state, 1);
    tick();
    chk("cnz_state",  state, 0);
    chk("cnz_retire", retire_count, 10);
    chk("cnz_pc",     imem_addr, 2);

    // reset during WRITEBACK
    imem_data = 16'h0000;
    tick(); tick(); tick();
    chk("rwb_pre", {state, reg_we}, {3'd4, 1'b1});
    reset = 1'b1; #1;
    chk("rwb_state",  state, 0);
    chk("rwb_strb",   {imem_req, decode, alu_en, dmem_req, dmem_we, reg_we}, 0);
    chk("rwb_retire", retire_count, 0);
    chk("rwb_pc",     imem_addr, 0);
    tick();
    chk("rwb_hold", {reg_we, dmem_req}, 0);
    reset = 1'b0; #1;
    chk("rwb_rel", {imem_req, reg_we}, 2'b10);

    // reset during MEM wait
    imem_data = 16'h3000;
    tick(); tick(); tick();
    chk("rmem_pre", {state, dmem_req}, {3'd3, 1'b1});
    reset = 1'b1; #1;
    chk("rmem_state", state, 0);
    chk("rmem_strb",  {dmem_req, dmem_we, reg_we}, 0);
    chk("rmem_ir",    ir, 0);
    tick();
    chk("rmem_hold", {dmem_req, reg_we}, 0);
    reset = 1'b0; #1;

    // HALT
    imem_data = 16'h3C00;
    tick(); tick();
    chk("halt_state",  {state, halted, imem_req}, {3'd5, 2'b10});
    chk("halt_retire", retire_count, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", {state, halted, imem_req, decode, alu_en, dmem_req, reg_we}, {3'd5, 6'b100000});
    end
    reset = 1'b1; #1;
    chk("halt_rst", {state, halted, imem_addr}, {3'd0, 1'b0, 8'h00});
    tick();
    reset = 1'b0; #1;
    chk("halt_rel", {state, imem_req}, {3'd0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
